// File: rtl/simon_pkg.sv
// Shared constants for the Simon game: LED modes, level encoding
// and default datapath geometry.
package simon_pkg;

   typedef enum logic [2:0] {
      LED_INPUT    = 3'b001,
      LED_PLAYBACK = 3'b010,
      LED_REPEAT   = 3'b100,
      LED_DONE     = 3'b111
   } led_mode_e;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 64;

   localparam logic LEVEL_EASY = 1'b1;
   localparam logic LEVEL_HARD = 1'b0;

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence store: synchronous write, asynchronous read, no reset.
// Callers gate every read so unwritten entries never reach an output.
module simon_seq_mem
   import simon_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_datapath_param.sv
// Simon datapath: sequence length/index counters, level latch,
// repeat compare and LED drive around the sequence store.
module simon_datapath_param
   import simon_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             level,
   input  logic [WIDTH-1:0] pattern,
   input  logic             clear_i,
   input  logic             increment_i,
   input  logic             clear_n,
   input  logic             increment_n,
   input  logic             write_pattern,
   input  logic             input_led_pattern,
   output logic             seq_remain,
   output logic             valid_repeat,
   output logic             valid_input,
   output logic             seq_full,
   output logic             overflow,
   output logic [AW:0]      seq_len,
   output logic [WIDTH-1:0] pattern_leds
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW:0]      n_q, n_d;
   logic [AW:0]      i_q, i_d;
   logic             lvl_q, lvl_d;
   logic             armed_q, armed_d;
   logic             ovf_q, ovf_d;
   logic             full;
   logic             we;
   logic [WIDTH-1:0] rdata;

   assign full = (n_q == DEPTH_C);
   assign we   = write_pattern && !full;

   always_comb begin
      n_d     = n_q;
      i_d     = i_q;
      lvl_d   = lvl_q;
      armed_d = armed_q;
      ovf_d   = ovf_q;
      if (clear_n) begin
         n_d = '0;
      end else if (increment_n && !full) begin
         n_d = n_q + 1'b1;
      end
      if (clear_i) begin
         i_d = '0;
      end else if (increment_i && (i_q != DEPTH_C)) begin
         i_d = i_q + 1'b1;
      end
      // a new game falls back to the hard rule until the level is re-sampled
      if (clear_n) begin
         armed_d = 1'b0;
         lvl_d   = LEVEL_HARD;
         ovf_d   = 1'b0;
      end else begin
         if (!armed_q) begin
            armed_d = 1'b1;
            lvl_d   = level;
         end
         if (write_pattern && full) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_q     <= '0;
         i_q     <= '0;
         lvl_q   <= LEVEL_HARD;
         armed_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         n_q     <= n_d;
         i_q     <= i_d;
         lvl_q   <= lvl_d;
         armed_q <= armed_d;
         ovf_q   <= ovf_d;
      end
   end

   simon_seq_mem #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_mem (
      .clk    (clk),
      .we_i   (we),
      .waddr_i(n_q[AW-1:0]),
      .wdata_i(pattern),
      .raddr_i(i_q[AW-1:0]),
      .rdata_o(rdata)
   );

   assign seq_remain   = (i_q < n_q);
   assign seq_full     = full;
   assign overflow     = ovf_q;
   assign seq_len      = n_q;
   assign valid_repeat = seq_remain && (rdata == pattern);
   assign valid_input  = (lvl_q == LEVEL_EASY) ||
                         ((pattern != '0) &&
                          ((pattern & (pattern - 1'b1)) == '0));
   assign pattern_leds = input_led_pattern ? pattern :
                         (seq_remain ? rdata : '0);

endmodule

// File: tb/tb_simon_datapath_param.sv
// Directed bench for simon_datapath_param with WIDTH=4, DEPTH=4.
// Expected values are hand-derived per step.
module tb_simon_datapath_param;

   localparam int W = 4;
   localparam int D = 4;
   localparam int A = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         level;
   logic [W-1:0] pattern;
   logic         clear_i;
   logic         increment_i;
   logic         clear_n;
   logic         increment_n;
   logic         write_pattern;
   logic         input_led_pattern;
   logic         seq_remain;
   logic         valid_repeat;
   logic         valid_input;
   logic         seq_full;
   logic         overflow;
   logic [A:0]   seq_len;
   logic [W-1:0] pattern_leds;

   int n_checks = 0;
   int n_fail   = 0;

   simon_datapath_param #(
      .WIDTH(W),
      .DEPTH(D)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .level            (level),
      .pattern          (pattern),
      .clear_i          (clear_i),
      .increment_i      (increment_i),
      .clear_n          (clear_n),
      .increment_n      (increment_n),
      .write_pattern    (write_pattern),
      .input_led_pattern(input_led_pattern),
      .seq_remain       (seq_remain),
      .valid_repeat     (valid_repeat),
      .valid_input      (valid_input),
      .seq_full         (seq_full),
      .overflow         (overflow),
      .seq_len          (seq_len),
      .pattern_leds     (pattern_leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clear_i       = 1'b0;
      increment_i   = 1'b0;
      clear_n       = 1'b0;
      increment_n   = 1'b0;
      write_pattern = 1'b0;
   endtask

   task automatic store(input logic [W-1:0] p);
      pattern       = p;
      write_pattern = 1'b1;
      increment_n   = 1'b1;
      tick();
      idle();
   endtask

   task automatic pulse_clear_n();
      clear_n = 1'b1;
      tick();
      idle();
   endtask

   task automatic pulse_clear_i();
      clear_i = 1'b1;
      tick();
      idle();
   endtask

   task automatic pulse_inc_i();
      increment_i = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      rst               = 1'b0;
      level             = 1'b1;
      pattern           = 4'b1001;
      input_led_pattern = 1'b1;
      idle();
      #2;
      check("rst_remain", seq_remain, 0);
      check("rst_vrep", valid_repeat, 0);
      check("rst_full", seq_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_len", seq_len, 0);
      check("rst_leds", pattern_leds, 4'b1001);
      check("rst_vin_two", valid_input, 0);
      pattern = 4'b0010;
      #1;
      check("rst_vin_one", valid_input, 1);
      input_led_pattern = 1'b0;
      #1;
      check("rst_leds_pb", pattern_leds, 0);

      // easy capture on first edge after release
      rst = 1'b1;
      tick();
      level   = 1'b0;
      pattern = 4'b1001;
      #1;
      check("easy_vin", valid_input, 1);
      pattern = 4'b0000;
      #1;
      check("easy_vin_zero", valid_input, 1);
      pattern = 4'b1001;
      pulse_clear_n();
      tick();
      check("hard_vin", valid_input, 0);

      // single round store and repeat
      store(4'b0100);
      check("r1_len", seq_len, 1);
      check("r1_remain", seq_remain, 1);
      check("r1_leds", pattern_leds, 4'b0100);
      check("r1_vrep", valid_repeat, 1);
      pulse_inc_i();
      check("r1_remain_end", seq_remain, 0);
      check("r1_leds_end", pattern_leds, 0);
      check("r1_vrep_end", valid_repeat, 0);

      // mismatch at index 1
      pulse_clear_n();
      store(4'b0001);
      store(4'b0010);
      pulse_clear_i();
      pulse_inc_i();
      pattern = 4'b0001;
      #1;
      check("mm_vrep_bad", valid_repeat, 0);
      check("mm_leds", pattern_leds, 4'b0010);
      pattern = 4'b0010;
      #1;
      check("mm_vrep_good", valid_repeat, 1);

      // fill to DEPTH then overflow
      pulse_clear_n();
      pulse_clear_i();
      store(4'b0001);
      store(4'b0010);
      store(4'b0100);
      check("fill3_full", seq_full, 0);
      store(4'b1000);
      check("fill4_full", seq_full, 1);
      check("fill4_len", seq_len, 4);
      check("fill4_ovf", overflow, 0);
      store(4'b1111);
      pattern = 4'b0110;
      #1;
      check("ovf_len", seq_len, 4);
      check("ovf_set", overflow, 1);
      check("ovf_mem0", pattern_leds, 4'b0001);
      tick();
      check("ovf_sticky", overflow, 1);

      // i saturates at DEPTH
      for (int k = 0; k < 8; k++) pulse_inc_i();
      check("i_sat_remain", seq_remain, 0);
      pulse_clear_n();
      check("clr_ovf", overflow, 0);
      check("clr_len", seq_len, 0);
      check("clr_full", seq_full, 0);

      // clear priorities
      pulse_clear_i();
      store(4'b0100);
      pulse_inc_i();
      check("pri_pre_remain", seq_remain, 0);
      clear_i     = 1'b1;
      increment_i = 1'b1;
      tick();
      idle();
      check("pri_clr_i", seq_remain, 1);
      store(4'b0001);
      clear_n     = 1'b1;
      increment_n = 1'b1;
      tick();
      idle();
      check("pri_clr_n", seq_len, 0);

      // async reset mid-game
      pulse_clear_i();
      store(4'b0001);
      store(4'b0010);
      store(4'b0100);
      pulse_inc_i();
      pulse_inc_i();
      check("mid_len", seq_len, 3);
      check("mid_remain", seq_remain, 1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_len", seq_len, 0);
      check("arst_remain", seq_remain, 0);
      check("arst_ovf", overflow, 0);
      check("arst_leds", pattern_leds, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
